// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI constants, framer state encoding, emitted frame payload
// and classification helpers for midi_byte_framer.
package midi_pkg;

   // Status nibbles (upper four bits of a status byte)
   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] CTRL     = 4'hB;
   localparam logic [3:0] PRG      = 4'hC;
   localparam logic [3:0] PITCH    = 4'hE;
   localparam logic [3:0] SYS      = 4'hF;

   localparam logic [7:0] SYX_START = 8'hF0;
   localparam logic [7:0] SYX_END   = 8'hF7;
   localparam logic [7:0] RT_FIRST  = 8'hF8;  // F8..FF are real-time bytes

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_GAP
   } framer_state_e;

   // One byte as presented to the decoder
   typedef struct packed {
      logic [7:0] status;
      logic [7:0] nr;
      logic [7:0] data;
   } midi_frame_t;

   // Number of data bytes that follow a given status byte
   function automatic logic [1:0] msg_len(input logic [7:0] status);
      logic [1:0] len;
      len = 2'd0;
      case (status[7:4])
         NOTE_OFF, NOTE_ON, 4'hA, CTRL, PITCH: len = 2'd2;
         PRG, 4'hD:                            len = 2'd1;
         SYS: begin
            case (status)
               8'hF1, 8'hF3: len = 2'd1;
               8'hF2:        len = 2'd2;
               default:      len = 2'd0;
            endcase
         end
         default: len = 2'd0;
      endcase
      return len;
   endfunction

   // Saturating increment used for data byte numbering
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/midi_byte_framer_if.sv
// midi_byte_framer_if: UART-side byte strobe plus decoder-side framed byte bus.
//   rx_valid/rx_byte       : byte strobe from the UART receiver
//   byteready              : stretched strobe, falling edge is the decoder event
//   cur_status/midibyte_nr/midibyte : framed byte
//   sysex_active/overflow  : status flags
// master = UART/decoder environment, slave = the framer.
interface midi_byte_framer_if;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       byteready;
   logic [7:0] cur_status;
   logic [7:0] midibyte_nr;
   logic [7:0] midibyte;
   logic       sysex_active;
   logic       overflow;

   modport master (
      output rx_valid, rx_byte,
      input  byteready, cur_status, midibyte_nr, midibyte, sysex_active, overflow
   );

   modport slave (
      input  rx_valid, rx_byte,
      output byteready, cur_status, midibyte_nr, midibyte, sysex_active, overflow
   );
endinterface

// File: rtl/midi_byte_fifo.sv
// midi_byte_fifo: first-word-fall-through synchronous byte FIFO.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i, din_i : write strobe and data (ignored while full)
//   pop_i         : advance read side (ignored while empty)
//   dout_o        : head entry, valid whenever empty_o is low (combinational)
//   full_o/empty_o: combinational occupancy flags
module midi_byte_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic [7:0] din_i,
   output logic [7:0] dout_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_q;
   logic [PW-1:0] rd_q;
   logic          do_push;
   logic          do_pop;

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Pointers carry one extra wrap bit to tell full from empty
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
            wr_q                <= wr_q + PW'(1);
         end
         if (do_pop) begin
            rd_q <= rd_q + PW'(1);
         end
      end
   end

endmodule

// File: rtl/midi_byte_framer.sv
// midi_byte_framer: buffers UART bytes, applies running status, numbers data
// bytes within each message and presents each accepted byte to the decoder
// with a stretched byteready pulse.
//   CLOCK_25 : system clock
//   iRST_N   : synchronous active-low reset
//   bus      : slave side of midi_byte_framer_if (rx strobe in, framed byte out)
module midi_byte_framer
   import midi_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PULSE_LEN  = 4,
   parameter int unsigned GAP_LEN    = 4
) (
   input  logic          CLOCK_25,
   input  logic          iRST_N,
   midi_byte_framer_if.slave bus
);

   localparam int unsigned TMAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   framer_state_e state_q;
   logic [TW-1:0] tmr_q;
   logic [7:0]    rs_q;        // running status, 00 = none
   logic [7:0]    cnt_q;       // data bytes seen in current message
   logic          syx_q;
   logic          byteready_q;
   logic          overflow_q;
   midi_frame_t   frame_q;

   logic          emit_d;
   midi_frame_t   frame_d;
   logic [7:0]    rs_d;
   logic [7:0]    cnt_d;
   logic          syx_d;
   logic [7:0]    cnt_inc;

   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;

   // Real-time bytes bypass everything
   assign fifo_push = bus.rx_valid && (bus.rx_byte < RT_FIRST);
   assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

   midi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (CLOCK_25),
      .rst_ni  (iRST_N),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   (bus.rx_byte),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Classify the FIFO head byte against the current message context
   always_comb begin
      emit_d  = 1'b0;
      frame_d = '0;
      rs_d    = rs_q;
      cnt_d   = cnt_q;
      syx_d   = syx_q;
      cnt_inc = sat_inc(cnt_q);
      if (fifo_dout == SYX_END) begin
         if (syx_q) begin
            emit_d         = 1'b1;
            frame_d.status = SYX_START;
            frame_d.nr     = cnt_inc;
            frame_d.data   = SYX_END;
            syx_d          = 1'b0;
            rs_d           = 8'h00;
            cnt_d          = 8'h00;
         end
      end else if (fifo_dout == SYX_START) begin
         emit_d         = 1'b1;
         frame_d.status = SYX_START;
         frame_d.nr     = 8'h00;
         frame_d.data   = SYX_START;
         syx_d          = 1'b1;
         rs_d           = SYX_START;
         cnt_d          = 8'h00;
      end else if (fifo_dout[7]) begin
         // Any other status aborts a sysex; data-less system common has no running status
         emit_d         = 1'b1;
         frame_d.status = fifo_dout;
         frame_d.nr     = 8'h00;
         frame_d.data   = fifo_dout;
         syx_d          = 1'b0;
         cnt_d          = 8'h00;
         rs_d           = ((fifo_dout[7:4] == SYS) && (msg_len(fifo_dout) == 2'd0)) ?
                          8'h00 : fifo_dout;
      end else if (rs_q != 8'h00) begin
         emit_d         = 1'b1;
         frame_d.status = rs_q;
         frame_d.nr     = cnt_inc;
         frame_d.data   = fifo_dout;
         if (rs_q == SYX_START) begin
            cnt_d = cnt_inc;
         end else if (cnt_inc == {6'd0, msg_len(rs_q)}) begin
            // Message complete: channel keeps running status, system common drops it
            cnt_d = 8'h00;
            if (rs_q[7:4] == SYS) begin
               rs_d = 8'h00;
            end
         end else begin
            cnt_d = cnt_inc;
         end
      end
   end

   // Framing FSM: IDLE pops, SETUP presents, PULSE/GAP share one down-counter
   always_ff @(posedge CLOCK_25) begin
      if (!iRST_N) begin
         state_q     <= ST_IDLE;
         tmr_q       <= '0;
         rs_q        <= 8'h00;
         cnt_q       <= 8'h00;
         syx_q       <= 1'b0;
         byteready_q <= 1'b0;
         overflow_q  <= 1'b0;
         frame_q     <= '0;
      end else begin
         if (fifo_push && fifo_full) begin
            overflow_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  rs_q  <= rs_d;
                  cnt_q <= cnt_d;
                  syx_q <= syx_d;
                  if (emit_d) begin
                     frame_q <= frame_d;
                     state_q <= ST_SETUP;
                  end
               end
            end
            ST_SETUP: begin
               byteready_q <= 1'b1;
               tmr_q       <= TW'(PULSE_LEN - 1);
               state_q     <= ST_PULSE;
            end
            ST_PULSE: begin
               if (tmr_q == '0) begin
                  byteready_q <= 1'b0;
                  tmr_q       <= TW'(GAP_LEN - 1);
                  state_q     <= ST_GAP;
               end else begin
                  tmr_q <= tmr_q - TW'(1);
               end
            end
            ST_GAP: begin
               if (tmr_q == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  tmr_q <= tmr_q - TW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.byteready    = byteready_q;
   assign bus.cur_status   = frame_q.status;
   assign bus.midibyte_nr  = frame_q.nr;
   assign bus.midibyte     = frame_q.data;
   assign bus.sysex_active = syx_q;
   assign bus.overflow     = overflow_q;

endmodule
